load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the ALU. Consumes the ALU result as the
//  effective address and issues one load/store per request to data memory over a
//  req/gnt + rvalid bus. Aligns and extends load data and returns it with rd to
//  writeback. Holds off the pipeline via lsu_ready while an access is in flight.
// PARAMETERS
//  TIMEOUT   255   max cycles spent in REQ+WAIT before abort; legal range 1..255
//  TMO_W     8     timeout counter width; must satisfy 2**TMO_W > TIMEOUT
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  ex_valid       in   1   request valid from execute stage
//  ex_is_load     in   1   request is a load
//  ex_is_store    in   1   request is a store
//  ex_funct3      in   3   width/sign: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
//  ex_addr        in   32  effective address (ALU result)
//  ex_wdata       in   32  store data (rs2)
//  ex_rd          in   5   load destination register
//  lsu_ready      out  1   1 only in IDLE; a request is accepted on ex_valid & lsu_ready
//  mem_req        out  1   memory request
//  mem_we         out  1   1 = write
//  mem_addr       out  32  word address: {addr[31:2],2'b00}
//  mem_wdata      out  32  lane-replicated store data
//  mem_wstrb      out  4   byte enables; 0000 on reads
//  mem_gnt        in   1   memory accepted the request this cycle
//  mem_rvalid     in   1   read data valid
//  mem_rdata      in   32  read data word
//  wb_valid       out  1   one-cycle pulse: load data valid
//  wb_rd          out  5   destination register for wb_data
//  wb_data        out  32  aligned, extended load result
//  st_done        out  1   one-cycle pulse: store granted
//  lsu_err        out  1   one-cycle pulse: request aborted
//  lsu_err_code   out  2   01 misaligned, 10 illegal funct3 or load&store, 11 timeout
// BEHAVIOUR
//  - Reset: state=IDLE, lsu_ready=1, every other output 0, timeout counter 0.
//    Reset mid-access drops mem_req asynchronously; no wb_valid or st_done follows.
//  - FSM states: IDLE, REQ, WAIT.
//  - IDLE, accept = ex_valid & (ex_is_load | ex_is_store):
//      illegal (both flags set, or funct3 not legal for the op) -> lsu_err, code 10, stay IDLE.
//      misaligned (half & addr[0]; word & addr[1:0]!=0) -> lsu_err, code 01, stay IDLE.
//      otherwise latch all ex_* fields, clear counter -> REQ.
//    ex_valid with neither flag set is ignored.
//    A rejected request never drives mem_req.
//  - REQ: mem_req=1 with stable latched fields until mem_gnt.
//    gnt & store -> st_done pulse, next IDLE. gnt & load -> WAIT.
//    mem_rvalid is ignored in REQ; rvalid is never in the same cycle as gnt.
//  - WAIT: mem_req=0. On mem_rvalid: wb_valid pulse with wb_rd/wb_data, next IDLE.
//    rd=x0 is still written back; the register file discards it.
//  - Timeout: counter increments each cycle in REQ/WAIT.
//    At count==TIMEOUT with no gnt/rvalid -> lsu_err, code 11, next IDLE, no wb.
//  - Store lanes:
//      SB  wdata={4{d[7:0]}},  wstrb=0001<<addr[1:0]
//      SH  wdata={2{d[15:0]}}, wstrb=addr[1]?1100:0011
//      SW  wdata=d,            wstrb=1111
//  - Load extract: byte = rdata>>(8*addr[1:0]); half = rdata>>(16*addr[1]).
//    LB/LH sign-extend to 32; LBU/LHU zero-extend; LW passes the word through.
//  - Throughput: store 2 cycles min (accept, gnt); load 3 cycles min (accept, gnt, rvalid).
//    Back-to-back requests are accepted the cycle after return to IDLE.
//  - Outputs registered except lsu_ready and mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb,
//    which decode from state and latched fields.
// STRUCTURE
//  - lsu_pkg: state enum, funct3 constants, err code constants.
//  - Sub-module load_data_align (combinational): (rdata, addr[1:0], funct3) -> wb_data.
// TESTING
//  1 SW addr 0x100 d 0xDEADBEEF, gnt 1 cycle later -> mem_addr 0x100, wstrb 1111,
//    st_done on gnt+1, lsu_ready low 2 cycles.
//  2 SB addr 0x103 d 0x000000A5 -> wdata 0xA5A5A5A5, wstrb 1000.
//    SH addr 0x102 d 0x1234 -> wstrb 1100.
//  3 LB addr 0x201 rdata 0x0000_80FF -> wb_data 0xFFFFFF80.
//    LBU -> 0x00000080. LHU addr 0x202 rdata 0x8001_0000 -> 0x00008001.
//  4 LW addr 0x102 -> lsu_err code 01, mem_req never asserts.
//    funct3 011 load -> code 10. load & store both set -> code 10.
//  5 Load granted, rvalid withheld TIMEOUT cycles -> lsu_err code 11, no wb_valid,
//    lsu_ready=1 next cycle.
//  6 rst asserted in WAIT -> mem_req/wb_valid 0 immediately; later rvalid ignored;
//    new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// State encoding, funct3 width codes, error codes and decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MISAL   = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(
    input logic       is_load,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    unique case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = is_load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load data alignment: picks the byte/half lane addressed by off_i from
// rdata_i and sign- or zero-extends it. Ports: rdata_i, off_i, funct3_i -> data_o.
module load_data_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[8*off_i +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = rdata_i;
    unique case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: takes the ALU result as effective address, issues one
// load/store over a req/gnt + rvalid bus, returns aligned load data to WB.
// Ports: ex_* request in, lsu_ready back-pressure, mem_* bus, wb_*/st_done
// completion pulses, lsu_err/lsu_err_code abort pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        lsu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        lsu_err,
  output logic [1:0]  lsu_err_code
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic              lat_en;

  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              st_done_q, st_done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              accept;
  logic              illegal;
  logic              misal;
  logic              tmo_hit;
  logic [31:0]       ld_data;

  load_data_align u_align (
    .rdata_i  (mem_rdata),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  assign accept  = ex_valid & (ex_is_load | ex_is_store);
  assign illegal = (ex_is_load & ex_is_store)
                 | ~f3_legal(ex_is_load, ex_funct3);
  assign misal   = is_misaligned(ex_funct3, ex_addr[1:0]);
  assign tmo_hit = (cnt_q == TMO_LIM);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_en     = 1'b0;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    st_done_d  = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (illegal) begin
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
          end else if (misal) begin
            err_d      = 1'b1;
            err_code_d = ERR_MISAL;
          end else begin
            lat_en  = 1'b1;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + TMO_W'(1);
        if (mem_gnt) begin
          if (we_q) begin
            st_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (tmo_hit) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + TMO_W'(1);
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = ld_data;
          state_d    = S_IDLE;
        end else if (tmo_hit) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      st_done_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      st_done_q  <= st_done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      if (lat_en) begin
        we_q    <= ex_is_store;
        f3_q    <= ex_funct3;
        addr_q  <= ex_addr;
        wdata_q <= ex_wdata;
        rd_q    <= ex_rd;
      end
    end
  end

  // Bus outputs are gated by state so nothing leaks outside REQ.
  assign lsu_ready = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;

  always_comb begin
    mem_wdata = '0;
    mem_wstrb = '0;
    if (mem_we) begin
      unique case (f3_q[1:0])
        2'b00: begin
          mem_wdata = {4{wdata_q[7:0]}};
          mem_wstrb = 4'b0001 << addr_q[1:0];
        end
        2'b01: begin
          mem_wdata = {2{wdata_q[15:0]}};
          mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          mem_wdata = wdata_q;
          mem_wstrb = 4'b1111;
        end
      endcase
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign st_done      = st_done_q;
  assign lsu_err      = err_q;
  assign lsu_err_code = err_code_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, random requests
// checked against an arithmetic model, plus timeout and reset sequences.
module tb_load_store_unit;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_ready, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done, lsu_err;
  logic [1:0]  lsu_err_code;

  int n_chk = 0;
  int n_pass = 0;

  load_store_unit #(.TIMEOUT(TIMEOUT), .TMO_W(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_ready(lsu_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .lsu_err(lsu_err),
    .lsu_err_code(lsu_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          gd;
    int          rdl;
    int          kind;
    logic [1:0]  code;
    logic [31:0] ewd;
    logic [3:0]  estrb;
    logic [31:0] edata;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(
    bit ld, bit st, logic [2:0] f3,
    logic [31:0] addr, logic [31:0] wd, logic [31:0] rdata,
    logic [4:0] rd, int gd, int rdl, int kind, logic [1:0] code,
    logic [31:0] ewd, logic [3:0] estrb, logic [31:0] edata);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr;
    v.wd = wd; v.rdata = rdata; v.rd = rd; v.gd = gd;
    v.rdl = rdl; v.kind = kind; v.code = code;
    v.ewd = ewd; v.estrb = estrb; v.edata = edata;
    return v;
  endfunction

  // Reference model: access size in bytes, derived from funct3.
  function automatic int m_size(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_illegal(bit ld, bit st, logic [2:0] f3);
    if (ld && st) return 1'b1;
    if (st) return f3 > 3'd2;
    return !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
  endfunction

  function automatic bit m_misal(logic [2:0] f3, logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3,
                                          logic [31:0] d);
    logic [31:0] r;
    case (m_size(f3))
      1:       r = {24'h0, d[7:0]} * 32'h01010101;
      2:       r = {16'h0, d[15:0]} * 32'h00010001;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] m_wstrb(logic [2:0] f3,
                                         logic [31:0] a);
    int m;
    m = ((1 << m_size(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3,
                                         logic [31:0] a,
                                         logic [31:0] rdata);
    logic [31:0] sh, mask, v;
    int n;
    n    = 8 * m_size(f3);
    sh   = rdata >> (8 * (a % 4));
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 1);
    v    = sh & mask;
    if (!f3[2] && n < 32 && v[n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic vec_t m_vec(bit ld, bit st, logic [2:0] f3,
                                 logic [31:0] a, logic [31:0] wd,
                                 logic [31:0] rdata, logic [4:0] rd,
                                 int gd, int rdl);
    vec_t v;
    v = mk(ld, st, f3, a, wd, rdata, rd, gd, rdl, 0, 2'b00,
           32'h0, 4'h0, 32'h0);
    if (!(ld || st)) v.kind = 2;
    else if (m_illegal(ld, st, f3)) begin
      v.kind = 1; v.code = 2'b10;
    end else if (m_misal(f3, a)) begin
      v.kind = 1; v.code = 2'b01;
    end else if (st) begin
      v.ewd = m_wdata(f3, wd); v.estrb = m_wstrb(f3, a);
    end else begin
      v.edata = m_load(f3, a, rdata);
    end
    return v;
  endfunction

  task automatic drive_req(bit ld, bit st, logic [2:0] f3,
                           logic [31:0] a, logic [31:0] wd,
                           logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic clear_req();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    @(posedge clk); #1;
    drive_req(v.ld, v.st, v.f3, v.addr, v.wd, v.rd);
    @(negedge clk);
    chk("accept_ready", {31'h0, lsu_ready}, 32'd1);
    chk("accept_noreq", {31'h0, mem_req}, 32'd0);
    @(posedge clk); #1;
    clear_req();
    if (v.kind != 0) begin
      @(negedge clk);
      chk("err_flag", {31'h0, lsu_err}, {31'h0, v.kind == 1});
      if (v.kind == 1)
        chk("err_code", {30'h0, lsu_err_code}, {30'h0, v.code});
      chk("reject_noreq", {31'h0, mem_req}, 32'd0);
      chk("reject_ready", {31'h0, lsu_ready}, 32'd1);
      return;
    end
    for (int k = 0; k <= v.gd; k++) begin
      mem_gnt = (k == v.gd);
      @(negedge clk);
      chk("req", {31'h0, mem_req}, 32'd1);
      chk("req_busy", {31'h0, lsu_ready}, 32'd0);
      if (k == 0) begin
        chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
        chk("mem_we", {31'h0, mem_we}, {31'h0, v.st});
        chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, v.estrb});
        if (v.st) chk("mem_wdata", mem_wdata, v.ewd);
      end
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
    if (v.st) begin
      @(negedge clk);
      chk("st_done", {31'h0, st_done}, 32'd1);
      chk("st_ready", {31'h0, lsu_ready}, 32'd1);
      chk("st_nowb", {31'h0, wb_valid}, 32'd0);
      return;
    end
    for (int k = 0; k <= v.rdl; k++) begin
      mem_rvalid = (k == v.rdl);
      mem_rdata  = (k == v.rdl) ? v.rdata : $urandom;
      @(negedge clk);
      chk("wait_noreq", {31'h0, mem_req}, 32'd0);
      chk("wait_nowb", {31'h0, wb_valid}, 32'd0);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("wb_valid", {31'h0, wb_valid}, 32'd1);
    chk("wb_rd", {27'h0, wb_rd}, {27'h0, v.rd});
    chk("wb_data", wb_data, v.edata);
    chk("ld_ready", {31'h0, lsu_ready}, 32'd1);
  endtask

  // Waits for the timeout abort; REQ+WAIT occupy cycles with count 0..TIMEOUT.
  task automatic run_timeout(input bit grant_first);
    int busy;
    bit seen, wbseen;
    busy = 0; seen = 1'b0; wbseen = 1'b0;
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd9);
    @(posedge clk); #1;
    clear_req();
    mem_gnt = grant_first;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge clk);
      if (!lsu_ready) busy++;
      if (wb_valid) wbseen = 1'b1;
      if (lsu_err) begin
        seen = 1'b1;
        chk("tmo_code", {30'h0, lsu_err_code}, 32'd3);
        chk("tmo_ready", {31'h0, lsu_ready}, 32'd1);
      end
      @(posedge clk); #1;
      mem_gnt = 1'b0;
    end
    chk("tmo_seen", {31'h0, seen}, 32'd1);
    chk("tmo_cycles", busy, TIMEOUT + 1);
    chk("tmo_nowb", {31'h0, wbseen}, 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    bit wbseen;
    rst = 1'b1;
    clear_req();
    ex_funct3 = 3'b000; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, lsu_ready}, 32'd1);
    chk("rst_req", {31'h0, mem_req}, 32'd0);
    chk("rst_we", {31'h0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wstrb", {28'h0, mem_wstrb}, 32'd0);
    chk("rst_wb", {31'h0, wb_valid}, 32'd0);
    chk("rst_st", {31'h0, st_done}, 32'd0);
    chk("rst_err", {31'h0, lsu_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    tbl.push_back(mk(0,1,3'b010,32'h100,32'hDEADBEEF,0,0,1,0,
                     0,0,32'hDEADBEEF,4'b1111,0));
    tbl.push_back(mk(0,1,3'b000,32'h103,32'h000000A5,0,0,0,0,
                     0,0,32'hA5A5A5A5,4'b1000,0));
    tbl.push_back(mk(0,1,3'b001,32'h102,32'h00001234,0,0,2,0,
                     0,0,32'h12341234,4'b1100,0));
    tbl.push_back(mk(0,1,3'b000,32'h101,32'h00000055,0,0,0,0,
                     0,0,32'h55555555,4'b0010,0));
    tbl.push_back(mk(1,0,3'b000,32'h201,0,32'h000080FF,5'd5,0,0,
                     0,0,0,4'h0,32'hFFFFFF80));
    tbl.push_back(mk(1,0,3'b100,32'h201,0,32'h000080FF,5'd6,1,2,
                     0,0,0,4'h0,32'h00000080));
    tbl.push_back(mk(1,0,3'b101,32'h202,0,32'h80010000,5'd7,0,1,
                     0,0,0,4'h0,32'h00008001));
    tbl.push_back(mk(1,0,3'b001,32'h302,0,32'h80017FFF,5'd8,0,0,
                     0,0,0,4'h0,32'hFFFF8001));
    tbl.push_back(mk(1,0,3'b010,32'h300,0,32'h12345678,5'd0,0,0,
                     0,0,0,4'h0,32'h12345678));
    tbl.push_back(mk(1,0,3'b010,32'h102,0,0,5'd1,0,0,
                     1,2'b01,0,0,0));
    tbl.push_back(mk(1,0,3'b011,32'h100,0,0,5'd1,0,0,
                     1,2'b10,0,0,0));
    tbl.push_back(mk(1,1,3'b010,32'h100,0,0,5'd1,0,0,
                     1,2'b10,0,0,0));
    tbl.push_back(mk(0,1,3'b100,32'h100,0,0,5'd1,0,0,
                     1,2'b10,0,0,0));
    tbl.push_back(mk(0,1,3'b001,32'h101,0,0,5'd1,0,0,
                     1,2'b01,0,0,0));
    tbl.push_back(mk(0,0,3'b010,32'h100,0,0,5'd1,0,0,
                     2,2'b00,0,0,0));

    foreach (tbl[i]) run_txn(tbl[i]);

    for (int i = 0; i < 80; i++) begin
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 19);
      ld  = $urandom_range(0, 1);
      st  = !ld;
      if (sel == 0) begin ld = 0; st = 0; end
      if (sel == 1) begin ld = 1; st = 1; end
      if (sel == 2) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      a = $urandom;
      if (sel > 4 && f3[1:0] != 2'b11)
        a = a & ~32'(m_size(f3) - 1);
      run_txn(m_vec(ld, st, f3, a, $urandom, $urandom,
                    5'($urandom_range(0, 31)),
                    $urandom_range(0, 3), $urandom_range(0, 3)));
    end

    run_timeout(1'b1);
    run_timeout(1'b0);

    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd3);
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    chk("rstA_req_on", {31'h0, mem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstA_req_drop", {31'h0, mem_req}, 32'd0);
    chk("rstA_ready", {31'h0, lsu_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'h0, 5'd4);
    @(posedge clk); #1;
    clear_req();
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("rstB_in_wait", {31'h0, lsu_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rstB_req", {31'h0, mem_req}, 32'd0);
    chk("rstB_wb", {31'h0, wb_valid}, 32'd0);
    chk("rstB_ready", {31'h0, lsu_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    wbseen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wb_valid) wbseen = 1'b1;
    end
    chk("rstB_stale_rvalid", {31'h0, wbseen}, 32'd0);
    run_txn(mk(1,0,3'b010,32'h508,0,32'h0BADF00D,5'd11,1,1,
               0,0,0,4'h0,32'h0BADF00D));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
